// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I byte-addressable data memory.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for RV32I accesses: store lane mask/replication or load lane select/extension.
// A zero lane_mask means the funct3/offset pair is illegal or misaligned for this access type.
module lsu_align
  import mem_pkg::*;
(
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] data_in,
  output logic [3:0]  lane_mask,
  output logic [31:0] data_out
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    lane_mask = 4'b0000;
    data_out  = '0;
    shifted   = data_in >> {byte_off, 3'b000};
    case (funct3)
      F3_B: begin
        lane_mask = 4'b0001 << byte_off;
        data_out  = is_load ? {{24{shifted[7]}}, shifted[7:0]} : {4{data_in[7:0]}};
      end
      F3_BU: if (is_load) begin
        lane_mask = 4'b0001 << byte_off;
        data_out  = {24'h0, shifted[7:0]};
      end
      F3_H: if (!byte_off[0]) begin
        lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
        data_out  = is_load ? {{16{shifted[15]}}, shifted[15:0]} : {2{data_in[15:0]}};
      end
      F3_HU: if (is_load && !byte_off[0]) begin
        lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
        data_out  = {16'h0, shifted[15:0]};
      end
      F3_W: if (byte_off == 2'b00) begin
        lane_mask = 4'b1111;
        data_out  = data_in;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32I data memory with registered load port, error detection
// and an optional post-reset zeroing sweep.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  idx;
  logic           oob, req_err, accept;
  logic [3:0]     st_mask, ld_mask;
  logic [31:0]    st_data, ld_data, rd_word;
  logic [2:0]     ld_f3_q;
  logic [1:0]     ld_off_q;

  assign ready  = (state_q == ST_RUN);
  assign idx    = req_addr[AW+1:2];
  assign oob    = |req_addr[31:AW+2];
  assign accept = req_valid && ready && !rst;
  assign req_err = oob || (st_mask == 4'b0000);

  lsu_align u_store_align (
    .is_load   (!req_we),
    .funct3    (req_funct3),
    .byte_off  (req_addr[1:0]),
    .data_in   (req_wdata),
    .lane_mask (st_mask),
    .data_out  (st_data)
  );

  lsu_align u_load_align (
    .is_load   (1'b1),
    .funct3    (ld_f3_q),
    .byte_off  (ld_off_q),
    .data_in   (rd_word),
    .lane_mask (ld_mask),
    .data_out  (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && cnt_q == LAST_IDX) state_d = ST_RUN;
  end

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // zeroing is done by the sweep instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++)
        if (st_mask[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
    end
    if (accept && !req_we) rd_word <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
    end else begin
      rsp_valid <= accept && (!req_we || req_err);
      rsp_err   <= accept && req_err;
      if (accept && !req_we) begin
        ld_f3_q  <= req_funct3;
        ld_off_q <= req_addr[1:0];
      end
    end
  end

  // Data is only driven for good loads; errors and idle cycles present zero.
  assign rsp_rdata = (rsp_valid && !rsp_err && ld_mask != 4'b0000) ? ld_data : '0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: a byte-array reference model queues expected
// responses; a negedge monitor compares them, plus ready, every cycle.
module tb_data_mem_lsu;

  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   clear_left = DEPTH;
  bit   mon_on = 1'b0;
  logic [7:0] mem_b [DEPTH*4];
  exp_t sb [$];

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference timing: memory becomes usable DEPTH cycles after the last reset cycle,
  // and at that point every word reads as zero.
  always @(posedge clk) begin
    cyc++;
    if (rst) clear_left = DEPTH;
    else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) foreach (mem_b[i]) mem_b[i] = 8'h00;
    end
  end

  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (mon_on) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      check("ready", ready, clear_left == 0);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end
    end
  end

  // Drive one request for one cycle and queue the response the reference model predicts.
  task automatic req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    exp_t        e;
    int          n;
    bit          err;
    logic [31:0] v;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (clear_left == 0 && !rst) begin
      n   = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
      err = (addr >> 2) >= DEPTH;
      if (addr % n != 0) err = 1'b1;
      if (we ? (f3 >= 3) : (f3 == 3 || f3 >= 6)) err = 1'b1;
      if (err) begin
        e.rdata = '0; e.err = 1'b1; e.due = cyc + 1;
        sb.push_back(e);
      end else if (we) begin
        for (int i = 0; i < n; i++) mem_b[addr[7:0] + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[addr[7:0] + i];
        if (f3 == 0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 1 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v; e.err = 1'b0; e.due = cyc + 1;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Count negedges with ready low; bounded so a stuck sweep still reaches the summary.
  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          we;

    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(negedge clk);
    check("reset_ready", ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", rsp_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(n);
    check("sweep_len", n, DEPTH);

    // Cleared memory, byte loads across a word
    req(0, 3'd2, 32'h0FC, 0);
    req(1, 3'd2, 32'h010, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) begin
      req(0, 3'd0, 32'h010 + i, 0);
      req(0, 3'd4, 32'h010 + i, 0);
    end

    // Partial stores merge into an existing word
    req(1, 3'd2, 32'h020, 32'h1122_3344);
    req(1, 3'd0, 32'h021, 32'h0000_00AA);
    req(0, 3'd2, 32'h020, 0);
    req(1, 3'd1, 32'h022, 32'h0000_BEEF);
    req(0, 3'd2, 32'h020, 0);
    req(0, 3'd1, 32'h022, 0);
    req(0, 3'd5, 32'h022, 0);

    // Error cases, then re-read to confirm nothing was written
    req(0, 3'd2, 32'h013, 0);
    req(1, 3'd1, 32'h021, 32'h0000_5555);
    req(1, 3'd2, 32'h100, 32'hFFFF_FFFF);
    req(0, 3'd3, 32'h020, 0);
    req(1, 3'd4, 32'h020, 32'h0000_0077);
    req(0, 3'd2, 32'h8000_0020, 0);
    req(0, 3'd2, 32'h020, 0);
    req(0, 3'd2, 32'h010, 0);

    // Store immediately followed by a load of the same word
    req(1, 3'd2, 32'h030, 32'h1234_5678);
    req(0, 3'd2, 32'h030, 0);
    idle();

    // Randomised mix of legal, misaligned, illegal and out-of-range traffic
    for (int k = 0; k < 300; k++) begin
      we = $urandom_range(0, 1);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : 3'($urandom_range(0, 1) ? $urandom_range(0, 2)
                                                                : $urandom_range(4, 5));
      addr = $urandom_range(0, 32'h10F);
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      case ($urandom_range(0, 9))
        0:       req(we, f3, $urandom, $urandom);
        1:       idle();
        default: req(we, f3, addr, $urandom);
      endcase
    end
    idle();

    // Reset in the middle of a sweep restarts it; requests during the sweep are ignored
    req(1, 3'd2, 32'h040, 32'hCAFE_F00D);
    req(0, 3'd2, 32'h040, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) req(1, 3'd2, 32'h000, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h000;
    req_wdata  = 32'hDEAD_BEEF;
    wait_ready(n);
    check("sweep_restart_len", n, DEPTH);
    req(0, 3'd2, 32'h040, 0);
    req(0, 3'd2, 32'h000, 0);
    req(0, 3'd2, 32'h010, 0);
    repeat (3) idle();

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised byte-addressable data memory for the RV32I core; successor to the word-only data memory.
- Adds byte/halfword/word loads and stores selected by RV32I funct3, with sign/zero extension.
- Adds a registered read port with a valid strobe, plus misalignment, out-of-range and illegal-funct3 detection.
- Adds an optional post-reset zeroing sweep with a ready flag. Sits between the execute stage (address/store data) and the writeback mux.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; power of two, >= 4
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = ready immediately

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
ready  output  1  high when requests are accepted
req_valid  input  1  request present this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  load response / error strobe, one cycle after request
rsp_rdata  output  32  extended load data
rsp_err  output  1  request was misaligned, out of range or illegal funct3

Behaviour:
- Reset values: ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, sweep counter=0. Memory contents are not reset directly.
- State machine: CLEAR, RUN.
  - rst forces CLEAR when CLEAR_ON_RESET=1, RUN otherwise; ready=1 only in RUN.
  - CLEAR: write 0 to word[cnt] each cycle; cnt increments; after cnt=DEPTH_WORDS-1 is written, go to RUN. Total DEPTH_WORDS cycles.
  - rst asserted mid-sweep restarts the sweep at word 0.
- Requests with req_valid=1 while ready=0 are ignored: no write, no response.
- Word index = req_addr[31:2]; oob = index >= DEPTH_WORDS. Upper address bits are never silently aliased.
- Error conditions; any of them sets err:
  - misaligned: funct3 half type with addr[0]=1, or word type with addr[1:0]!=0;
  - oob;
  - illegal funct3: load with 3/6/7, or store with funct3 >= 3.
- Store, no err: on the request posedge, write only the addressed byte lanes.
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - SW: all lanes.
  - Other lanes are unchanged.
- Store with err: no write, rsp_valid=1 and rsp_err=1 next cycle, rsp_rdata=0.
- Error-free store: rsp_valid=0 (stores are not acknowledged).
- Load: array read registered on the request posedge; funct3 and addr[1:0] registered alongside.
  - Next cycle: rsp_valid=1 and rsp_rdata = selected lane(s). LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Load with err: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Latency: load data one cycle after acceptance; back-to-back loads give a response every cycle.
- Store at cycle N followed by a load of the same word at N+1 returns the new data (write precedes the read in array order). No same-cycle conflict exists: one request per cycle.
- rsp_valid is a one-cycle pulse per accepted load or erroring request; it is 0 in cycles with no accepted request.
- rst during RUN: the response registers clear on the same edge; any request in that cycle is dropped; memory keeps its contents when CLEAR_ON_RESET=0.

Decomposition:
- Package mem_pkg: localparams F3_B/F3_H/F3_W/F3_BU/F3_HU, and a state enum (CLEAR, RUN).
- Sub-module lsu_align (combinational), used twice:
  - store lane-mask/data replication from funct3 and addr[1:0];
  - load lane select plus extension from the registered funct3 and addr[1:0].
- Top holds the array, FSM, sweep counter and response registers.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH_WORDS=64: pulse rst 1 cycle -> ready=0 for exactly 64 cycles, then 1; LW from 0x0FC -> rsp_rdata=0x00000000.
- SW 0x80FF7F01 @0x10, then LB/LBU @0x10..0x13 -> 0x00000001, 0x0000007F/0x0000007F, 0xFFFFFFFF/0x000000FF, 0xFFFFFF80/0x00000080.
- SB 0xAA @0x21 over word 0x11223344 @0x20, then LW @0x20 -> 0x1122AA44; SH 0xBEEF @0x22 -> LW 0xBEEFAA44; LH @0x22 -> 0xFFFFBEEF.
- LW @0x13, SH @0x21, SW @0x100 (oob at 64 words), load funct3=3 -> rsp_valid=1, rsp_err=1, rsp_rdata=0 each; memory unchanged on re-read.
- Back-to-back SW 0x12345678 @0x30 then LW @0x30 next cycle -> rsp_valid one cycle later with 0x12345678; req_valid during CLEAR -> no rsp_valid, no write.
- Assert rst at sweep count 20 -> ready stays 0 for a further 64 cycles; word previously written (CLEAR_ON_RESET=1) reads 0.
